// File: rtl/nibble_serial_adder_pkg.sv
// nsa_pkg: shared FSM states, digit width and index sizing for nibble_serial_adder
package nsa_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DIGIT_W = 4;
   function automatic int idx_w(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction
endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: request/result bundle; carries bcd only when NIBBLE_SERIAL_ADDER_BCD_EN is defined
interface nibble_serial_adder_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
   logic             bcd;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             zero;
   logic             overflow;
   modport master (
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
      output bcd,
`endif
      output start, a, b, cin, sub,
      input  busy, done, s, cout, zero, overflow
   );
   modport slave (
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
      input  bcd,
`endif
      input  start, a, b, cin, sub,
      output busy, done, s, cout, zero, overflow
   );
endinterface

// File: rtl/nibble_serial_adder_digit_adder.sv
// digit_adder: 4-bit plus carry adder; decimal adjust added when NIBBLE_SERIAL_ADDER_BCD_EN is defined
module digit_adder
   import nsa_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               ci,
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
   input  logic               bcd,
`endif
   output logic [DIGIT_W-1:0] sum,
   output logic               co
);
   logic [DIGIT_W:0] raw;
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
   logic adj;
`endif
   // raw binary digit sum, pushed back into 0..9 when adding decimal digits
   always_comb begin
      raw = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
      adj = bcd && raw > 5'd9;
      sum = adj ? raw[DIGIT_W-1:0] + 4'd6 : raw[DIGIT_W-1:0];
      co  = adj ? 1'b1 : raw[DIGIT_W];
`else
      sum = raw[DIGIT_W-1:0];
      co  = raw[DIGIT_W];
`endif
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: digit-serial add/subtract with start/busy/done; BCD mode via NIBBLE_SERIAL_ADDER_BCD_EN
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   nibble_serial_adder_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int IW   = idx_w(NDIG);

   if (WIDTH % DIGIT_W != 0 || WIDTH < DIGIT_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state, state_nx;
   logic [WIDTH-1:0]   a_sh, b_sh, s_r, s_nx;
   logic [IW-1:0]      idx;
   logic [DIGIT_W-1:0] dsum;
   logic               carry, dco, a_msb, b_msb, accept, last, ovf_nx;
   logic               cout_r, zero_r, ovf_r;
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
   logic               bcd_r;
`endif

   assign accept       = bus.start && state != RUN;
   assign last         = idx == IW'(NDIG - 1);
   assign bus.busy     = state == RUN;
   assign bus.done     = state == DONE;
   assign bus.s        = s_r;
   assign bus.cout     = cout_r;
   assign bus.zero     = zero_r;
   assign bus.overflow = ovf_r;

   digit_adder u_dig (
      .x   (a_sh[DIGIT_W-1:0]),
      .y   (b_sh[DIGIT_W-1:0]),
      .ci  (carry),
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
      .bcd (bcd_r),
`endif
      .sum (dsum),
      .co  (dco)
   );

   // next state, and the result with the current digit merged in
   always_comb begin
      state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
      s_nx = s_r;
      s_nx[DIGIT_W*idx +: DIGIT_W] = dsum;
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
      ovf_nx = !bcd_r && a_msb == b_msb && s_nx[WIDTH-1] != a_msb;
`else
      ovf_nx = a_msb == b_msb && s_nx[WIDTH-1] != a_msb;
`endif
   end

   // state register; reset wins over a simultaneous start
   always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

   // operand latch/shift, carry ripple, and result/flag capture on the last digit
   always_ff @(posedge clk) begin
      if (reset) begin
         idx    <= '0;
         carry  <= 1'b0;
         s_r    <= '0;
         cout_r <= 1'b0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.cin ^ bus.sub;
         idx   <= '0;
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1] ^ bus.sub;
`ifdef NIBBLE_SERIAL_ADDER_BCD_EN
         bcd_r <= bus.bcd && !bus.sub;
`endif
      end else if (state == RUN) begin
         a_sh  <= a_sh >> DIGIT_W;
         b_sh  <= b_sh >> DIGIT_W;
         carry <= dco;
         idx   <= idx + 1'b1;
         s_r   <= s_nx;
         if (last) begin
            cout_r <= dco;
            zero_r <= s_nx == '0;
            ovf_r  <= ovf_nx;
         end
      end
   end
endmodule
